// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default reset PC / bubble instruction, and a PC word-alignment helper.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // request outstanding on the bus (imem_req=1)
    S_WAIT  = 2'd1,  // granted, waiting for rvalid
    S_HOLD  = 2'd2,  // response captured in skid buffer, decode stalled
    S_DRAIN = 2'd3   // granted request was killed by flush; swallow its response
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id.sv
// IF/ID pipeline register.
// Priority: flush (clear to bubble, pc=0) > stall (hold) > load > bubble.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush_i, stall_i   hazard/branch controls
//   load_i             an instruction is transferred in this cycle
//   load_pc_i/inst_i   PC and instruction word to load
//   pc_o/inst_o/valid_o registered IF/ID contents
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic [31:0] load_inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] inst_q,  inst_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (stall_i) begin
      // hold all fields
    end else if (load_i) begin
      pc_d    = load_pc_i;
      inst_d  = load_inst_i;
      valid_d = 1'b1;
    end else begin
      // bubble keeps the last pc; only valid/inst are cleared
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem
// req/gnt/rvalid handshake, one-entry skid buffer for responses that arrive
// while decode is stalled, and the IF/ID register.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   npc_i, pc_o               next-PC in, current PC out
//   stall, flush              hazard / redirect controls
//   imem_req/addr/gnt         request channel (addr == pc_o)
//   imem_rvalid/rdata         response channel
//   if_id_pc/inst/valid       IF/ID register contents
//   fetch_busy                no instruction delivered this cycle
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_i,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] pc_o,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q,    pc_d;
  logic [31:0]  skid_q,  skid_d;
  logic         advance;
  logic [31:0]  adv_inst;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    skid_d   = skid_q;
    advance  = 1'b0;
    adv_inst = imem_rdata;
    unique case (state_q)
      S_REQ: begin
        if (flush) begin
          pc_d = word_align(npc_i);
          // a request granted in the flush cycle still returns data; drain it
          if (imem_gnt) state_d = S_DRAIN;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_d    = word_align(npc_i);
          state_d = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          if (!stall) begin
            advance = 1'b1;
            pc_d    = word_align(npc_i);
            state_d = S_REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_d    = word_align(npc_i);
          state_d = S_REQ;
        end else if (!stall) begin
          advance  = 1'b1;
          adv_inst = skid_q;
          pc_d     = word_align(npc_i);
          state_d  = S_REQ;
        end
      end
      S_DRAIN: begin
        if (flush) pc_d = word_align(npc_i);
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  assign pc_o       = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == S_REQ) && !rst;
  assign fetch_busy = !advance && !stall;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .stall_i    (stall),
    .load_i     (advance),
    .load_pc_i  (pc_q),
    .load_inst_i(adv_inst),
    .pc_o       (if_id_pc),
    .inst_o     (if_id_inst),
    .valid_o    (if_id_valid)
  );

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage between the next-PC logic and the decode stage.
- Holds the architectural PC register and drives it to the next-PC logic.
- Issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Buffers the response and loads the IF/ID pipeline register.
- Honours stall and flush from the hazard/branch logic, including requests already outstanding to memory when a flush arrives.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction placed in IF/ID on a bubble (addi x0,x0,0).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  synchronous active-high reset.
npc_i  in  32  next PC from next-PC logic; sampled only when the stage advances or on flush.
stall  in  1  decode stage cannot accept; hold IF/ID.
flush  in  1  redirect (taken branch/jump); npc_i carries the target this cycle.
pc_o  out  32  current PC register, fed back to next-PC logic.
imem_req  out  1  request valid.
imem_addr  out  32  request address, always equal to pc_o.
imem_gnt  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response valid; at most one outstanding.
imem_rdata  in  32  instruction word, valid with imem_rvalid.
if_id_pc  out  32  PC of the instruction in IF/ID.
if_id_inst  out  32  instruction in IF/ID.
if_id_valid  out  1  IF/ID holds a real instruction.
fetch_busy  out  1  no instruction delivered this cycle; to hazard unit.

Behaviour:
- Reset (sync, rst=1 at edge): pc_q=RESET_PC, state=S_REQ, if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0, skid buffer empty. imem_req=0 while rst=1.
- PC loads are word-aligned: pc_q <= {npc_i[31:2],2'b00}.
- The stage advances when an instruction is transferred into IF/ID. On advance: pc_q<=npc_i, IF/ID<={pc_q,inst,1}.
- S_REQ: imem_req=1.
  - flush, no gnt: pc_q<=npc_i; stay S_REQ.
  - flush with gnt: pc_q<=npc_i; ->S_DRAIN.
  - gnt, no flush: ->S_WAIT.
- S_WAIT: imem_req=0.
  - flush (with or without rvalid): pc_q<=npc_i. With rvalid, discard the response and ->S_REQ. Without rvalid, ->S_DRAIN.
  - rvalid, !stall: advance; ->S_REQ.
  - rvalid, stall: capture rdata into skid buffer; ->S_HOLD.
- S_HOLD: imem_req=0.
  - flush: drop the buffer, pc_q<=npc_i, ->S_REQ.
  - !stall: advance from the buffer; ->S_REQ.
- S_DRAIN: imem_req=0.
  - rvalid: discard the response; ->S_REQ.
  - flush while draining: pc_q<=npc_i, stay S_DRAIN.
- IF/ID register priority:
  1. flush: valid=0, inst=NOP_INST, pc=0. Flush beats stall.
  2. stall: hold all three fields.
  3. advance: load.
  4. otherwise: bubble (valid=0, inst=NOP_INST).
- fetch_busy=1 in every cycle without an advance, except cycles where stall=1.
- Latency:
  - Zero-wait memory (gnt in S_REQ, rvalid the next cycle): 2 cycles per instruction, pc_o to IF/ID.
  - rvalid delayed k cycles after gnt: adds k cycles.
- Address wrap: pc_q wraps mod 2^32; no trap.
- A response with no request outstanding (rvalid outside S_WAIT/S_DRAIN) is ignored.
- Reset mid-transaction: state returns to S_REQ. Any response arriving later is ignored by the rule above; the memory side must be reset with the same rst.

Decomposition:
- Shared package/defines: state encodings S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2, S_DRAIN=2'd3; NOP_INST constant; RESET_PC default. These go into the existing ctrl-encode defines file.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with flush>stall>load>bubble priority.
- The FSM, PC register and skid buffer stay in if_fetch_stage.

Test Plan:
1. Reset, then zero-wait memory returning addr as data, stall=flush=0, npc_i=pc_o+4 → IF/ID shows pc 0,4,8 with inst=pc, valid=1 every 2nd cycle; first valid 2 cycles after rst drops.
2. Stall held 3 cycles while rvalid arrives with pc=8 → state S_HOLD, IF/ID unchanged; on stall release the cycle after, IF/ID={8,rdata,1}, pc_o=12.
3. Flush with npc_i=0x100 in the same cycle as gnt for pc=0x10 → S_DRAIN; the rvalid data 0xDEADBEEF is never in IF/ID; next request addr=0x100.
4. Flush and stall together while IF/ID valid → IF/ID valid=0, inst=0x13; pc_o=npc_i target.
5. rvalid delayed 4 cycles after gnt → fetch_busy=1 for those cycles, imem_req=0; single outstanding request observed.
6. rst asserted in S_WAIT, then a stray rvalid 2 cycles later → ignored; first request after reset is addr=RESET_PC.
